// File: rtl/vec_regfile_seq.sv
// Grouped vector register file with a sequenced, masked group write path.
// Optional macro VRF_TAIL_AGNOSTIC_EN: tail elements are written all-ones.
module vec_regfile_seq #(
   parameter int VLEN     = 512,
   parameter int NUM_REGS = 32,
   parameter int MAX_LMUL = 8,
   parameter int AW       = $clog2(NUM_REGS),
   parameter int VLW      = $clog2(VLEN) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [AW-1:0]            raddr_1,
   input  logic [AW-1:0]            raddr_2,
   input  logic [3:0]               lmul,
   output logic [MAX_LMUL*VLEN-1:0] rdata_1,
   output logic [MAX_LMUL*VLEN-1:0] rdata_2,
   output logic [MAX_LMUL*VLEN-1:0] dst_data,
   output logic                     wrong_addr,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [AW-1:0]            waddr,
   input  logic [MAX_LMUL*VLEN-1:0] wdata,
   input  logic [1:0]               sew,
   input  logic [VLW-1:0]           vl,
   input  logic                     mask_operation,
   input  logic                     mask_wr_en,
   input  logic [VLEN-1:0]          mask_wdata,
   output logic [VLEN-1:0]          v0_mask_data,
   output logic                     busy,
   output logic                     data_written,
   output logic                     wr_err
);

   localparam int DW = MAX_LMUL * VLEN;
   localparam int NB = VLEN / 8;
   localparam int KW = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;
   localparam int EW = $clog2(VLEN);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [VLEN-1:0] regs [NUM_REGS];

   logic [AW-1:0]   waddr_q;
   logic [DW-1:0]   wdata_q;
   logic [3:0]      lmul_q;
   logic [1:0]      sew_q;
   logic [VLW-1:0]  vl_q;
   logic            mop_q;
   logic [VLEN-1:0] snap_q;
   logic [KW-1:0]   k_q;
   logic            dw_q;
   logic            err_q;

   logic            accept;
   logic            waddr_ok;
   logic            last_k;
   logic [AW-1:0]   wreg;
   logic [VLEN-1:0] wslice;

   function automatic logic lmul_ok(input logic [3:0] lm);
      return (lm == 4'd1 || lm == 4'd2 ||
              lm == 4'd4 || lm == 4'd8) &&
             (int'(lm) <= MAX_LMUL);
   endfunction

   function automatic logic grp_ok(
      input logic [AW-1:0] a,
      input logic [3:0]    lm
   );
      if (!lmul_ok(lm)) return 1'b0;
      return ((a & AW'(lm - 4'd1)) == '0) &&
             (int'(a) + int'(lm) <= NUM_REGS);
   endfunction

   function automatic logic [DW-1:0] read_grp(
      input logic [AW-1:0] a,
      input logic [3:0]    lm
   );
      logic [DW-1:0] g;
      g = '0;
      if (grp_ok(a, lm)) begin
         for (int j = 0; j < MAX_LMUL; j++) begin
            if (j < int'(lm))
               g[j*VLEN +: VLEN] = regs[a + AW'(j)];
         end
      end
      return g;
   endfunction

   assign rdata_1  = read_grp(raddr_1, lmul);
   assign rdata_2  = read_grp(raddr_2, lmul);
   assign dst_data = read_grp(waddr, lmul);

   assign wrong_addr = !grp_ok(raddr_1, lmul) ||
                       !grp_ok(raddr_2, lmul) ||
                       !grp_ok(waddr, lmul);

   assign wr_ready     = (state_q == IDLE) && !mask_wr_en;
   assign accept       = wr_valid && wr_ready;
   assign waddr_ok     = grp_ok(waddr, lmul);
   assign busy         = (state_q != IDLE);
   assign data_written = dw_q;
   assign wr_err       = err_q;
   assign v0_mask_data = regs[0];

   assign wreg   = waddr_q + AW'(k_q);
   assign last_k = (4'(k_q) == lmul_q - 4'd1);

   // Merge slice k of the latched data into the target register, byte-wise.
   always_comb begin
      wslice = regs[wreg];
      for (int j = 0; j < NB; j++) begin
         int   gb;
         int   e;
         logic body;
         logic en;
         gb   = int'(k_q) * NB + j;
         e    = gb >> sew_q;
         body = (e < int'(vl_q));
         en   = body && (e < VLEN) &&
                (!mop_q || snap_q[e[EW-1:0]]);
         if (en)
            wslice[j*8 +: 8] = wdata_q[gb*8 +: 8];
`ifdef VRF_TAIL_AGNOSTIC_EN
         else if (!body)
            wslice[j*8 +: 8] = 8'hFF;
`endif
      end
   end

   // Sequencer next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && waddr_ok) state_d = WRITE;
         WRITE:   if (last_k) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, request latch and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         dw_q    <= 1'b0;
         err_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         lmul_q  <= '0;
         sew_q   <= '0;
         vl_q    <= '0;
         mop_q   <= 1'b0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         dw_q    <= (state_q == DONE);
         err_q   <= accept && !waddr_ok;
         if (state_q == WRITE)
            k_q <= k_q + 1'b1;
         if (accept) begin
            k_q     <= '0;
            waddr_q <= waddr;
            wdata_q <= wdata;
            lmul_q  <= lmul;
            sew_q   <= sew;
            vl_q    <= vl;
            mop_q   <= mask_operation;
            snap_q  <= regs[0];
         end
      end
   end

   // Register array: one sequenced write or a direct v0 write per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (state_q == WRITE) begin
         regs[wreg] <= wslice;
      end else if (state_q == IDLE && mask_wr_en) begin
         regs[0] <= mask_wdata;
      end
   end

endmodule

// File: tb/tb_vec_regfile_seq.sv
// Scoreboard bench for vec_regfile_seq.
// Honours VRF_TAIL_AGNOSTIC_EN in its reference model.
module tb_vec_regfile_seq;

   localparam int VLEN     = 512;
   localparam int NUM_REGS = 32;
   localparam int MAX_LMUL = 8;
   localparam int AW       = 5;
   localparam int VLW      = 10;
   localparam int DW       = MAX_LMUL * VLEN;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [AW-1:0]   raddr_1 = '0;
   logic [AW-1:0]   raddr_2 = '0;
   logic [3:0]      lmul = 4'd1;
   logic [DW-1:0]   rdata_1, rdata_2, dst_data;
   logic            wrong_addr;
   logic            wr_valid = 1'b0;
   logic            wr_ready;
   logic [AW-1:0]   waddr = '0;
   logic [DW-1:0]   wdata = '0;
   logic [1:0]      sew = '0;
   logic [VLW-1:0]  vl = '0;
   logic            mask_operation = 1'b0;
   logic            mask_wr_en = 1'b0;
   logic [VLEN-1:0] mask_wdata = '0;
   logic [VLEN-1:0] v0_mask_data;
   logic            busy, data_written, wr_err;

   vec_regfile_seq #(
      .VLEN(VLEN), .NUM_REGS(NUM_REGS), .MAX_LMUL(MAX_LMUL)
   ) dut (
      .clk(clk), .reset(reset),
      .raddr_1(raddr_1), .raddr_2(raddr_2), .lmul(lmul),
      .rdata_1(rdata_1), .rdata_2(rdata_2), .dst_data(dst_data),
      .wrong_addr(wrong_addr),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .waddr(waddr), .wdata(wdata), .sew(sew), .vl(vl),
      .mask_operation(mask_operation),
      .mask_wr_en(mask_wr_en), .mask_wdata(mask_wdata),
      .v0_mask_data(v0_mask_data),
      .busy(busy), .data_written(data_written), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [VLEN-1:0] mdl [NUM_REGS];

   typedef struct {
      logic [DW-1:0] grp;
      int            due;
   } exp_t;

   exp_t sbq[$];

   function automatic logic [DW-1:0] mdl_grp(input int a, input int lm);
      logic [DW-1:0] g;
      g = '0;
      for (int j = 0; j < lm; j++) g[j*VLEN +: VLEN] = mdl[a+j];
      return g;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic model_write(input int a, input int lm,
                              input logic [DW-1:0] d,
                              input int s, input int v,
                              input logic mop);
      logic [VLEN-1:0] snap;
      int sz, epr, vc, e;
      snap = mdl[0];
      sz   = 8 << s;
      epr  = VLEN / sz;
      vc   = (v > lm*epr) ? lm*epr : v;
      for (int k = 0; k < lm; k++) begin
         for (int i = 0; i < epr; i++) begin
            e = k*epr + i;
            for (int b = 0; b < sz; b++) begin
               if (e < vc && (!mop || snap[e]))
                  mdl[a+k][i*sz+b] = d[k*VLEN + i*sz + b];
`ifdef VRF_TAIL_AGNOSTIC_EN
               else if (e >= vc)
                  mdl[a+k][i*sz+b] = 1'b1;
`endif
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset && data_written === 1'b1) begin
         exp_t x;
         n_chk++;
         if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_data_written cyc=%0d", cyc);
         end else begin
            x = sbq.pop_front();
            if (cyc !== x.due) begin
               n_fail++;
               $display("FAIL dw_latency got cyc %0d want %0d", cyc, x.due);
            end
            n_chk++;
            if (dst_data !== x.grp) begin
               n_fail++;
               $display("FAIL dst_data got %h want %h",
                        dst_data[63:0], x.grp[63:0]);
            end
         end
      end
   end

   task automatic start_write(input int a, input int lm,
                              input logic [DW-1:0] d,
                              input int s, input int v,
                              input logic mop);
      exp_t x;
      int t;
      t = 0;
      @(negedge clk);
      while (wr_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_wait got %b want 1", wr_ready);
      end
      waddr = AW'(a);
      lmul = 4'(lm);
      wdata = d;
      sew = 2'(s);
      vl = VLW'(v);
      mask_operation = mop;
      wr_valid = 1'b1;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      model_write(a, lm, d, s, v, mop);
      x.grp = mdl_grp(a, lm);
      x.due = cyc + lm + 1;
      sbq.push_back(x);
   endtask

   task automatic wait_done(output int bc);
      int t;
      bc = 0;
      t = 0;
      @(negedge clk);
      while (busy === 1'b1 && t < 30) begin
         bc++;
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL write_done pending %0d want 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic check_read(input int a, input int lm);
      logic [DW-1:0] e;
      @(negedge clk);
      raddr_1 = AW'(a);
      raddr_2 = AW'(a);
      lmul = 4'(lm);
      waddr = '0;
      #1;
      e = mdl_grp(a, lm);
      n_chk++;
      if (rdata_1 !== e || rdata_2 !== e) begin
         n_fail++;
         $display("FAIL read r%0d l%0d got %h want %h",
                  a, lm, rdata_1[63:0], e[63:0]);
      end
      n_chk++;
      if (wrong_addr !== 1'b0) begin
         n_fail++;
         $display("FAIL read_wrong_addr got %b want 0", wrong_addr);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || data_written !== 1'b0 || wr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status got %b%b%b want 000",
                  busy, data_written, wr_err);
      end
      n_chk++;
      if (v0_mask_data !== '0 || rdata_1 !== '0) begin
         n_fail++;
         $display("FAIL reset_regs got %h want 0", v0_mask_data[63:0]);
      end
      reset = 1'b0;
      @(negedge clk);
      n_chk++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 1", wr_ready);
      end
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      int bc;
      d = '0;
      d[31:0] = 32'hDEADBEEF;
      start_write(5, 1, d, 2, 16, 1'b0);
      wait_done(bc);
      n_chk++;
      if (bc != 2) begin
         n_fail++;
         $display("FAIL single_busy got %0d want 2", bc);
      end
      check_read(5, 1);
      n_chk++;
      if (rdata_1[31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL single_word got %h want deadbeef", rdata_1[31:0]);
      end
   endtask

   task automatic test_group4();
      logic [DW-1:0] d;
      int bc;
      d = '0;
      for (int w = 0; w < 4*VLEN/32; w++) d[w*32 +: 32] = $urandom ^ w;
      start_write(8, 4, d, 3, VLEN, 1'b0);
      wait_done(bc);
      n_chk++;
      if (bc != 5) begin
         n_fail++;
         $display("FAIL group4_busy got %0d want 5", bc);
      end
      check_read(8, 4);
      n_chk++;
      if (rdata_1[4*VLEN-1:0] !== d[4*VLEN-1:0]) begin
         n_fail++;
         $display("FAIL group4_data got %h want %h",
                  rdata_1[VLEN*3 +: 64], d[VLEN*3 +: 64]);
      end
      @(negedge clk);
      raddr_1 = 5'd9;
      raddr_2 = 5'd8;
      lmul = 4'd4;
      #1;
      n_chk++;
      if (wrong_addr !== 1'b1 || rdata_1 !== '0) begin
         n_fail++;
         $display("FAIL misalign_read got wa=%b d=%h want 1/0",
                  wrong_addr, rdata_1[63:0]);
      end
   endtask

   task automatic test_mask();
      logic [DW-1:0] d;
      int bc;
      @(negedge clk);
      mask_wr_en = 1'b1;
      mask_wdata = '0;
      mask_wdata[15:0] = 16'h00FF;
      waddr = 5'd4;
      lmul = 4'd1;
      wr_valid = 1'b1;
      #1;
      n_chk++;
      if (wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_ready got %b want 0", wr_ready);
      end
      @(posedge clk);
      #1;
      mask_wr_en = 1'b0;
      wr_valid = 1'b0;
      mdl[0] = mask_wdata;
      @(negedge clk);
      n_chk++;
      if (v0_mask_data !== mdl[0] || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL v0_write got %h b=%b want %h",
                  v0_mask_data[31:0], busy, mdl[0][31:0]);
      end
      d = {(DW/8){8'hA5}};
      start_write(2, 1, d, 2, 16, 1'b1);
      wait_done(bc);
      check_read(2, 1);
      n_chk++;
      if (rdata_1[255:0] !== {32{8'hA5}} || rdata_1[511:256] !== '0) begin
         n_fail++;
         $display("FAIL masked_write got %h want a5 low/0 high",
                  rdata_1[287:224]);
      end
   endtask

   task automatic test_wr_err();
      @(negedge clk);
      waddr = 5'd7;
      lmul = 4'd2;
      wr_valid = 1'b1;
      #1;
      n_chk++;
      if (wrong_addr !== 1'b1 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL err_addr got wa=%b rdy=%b want 1/1",
                  wrong_addr, wr_ready);
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (wr_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pulse got e=%b b=%b want 1/0", wr_err, busy);
      end
      @(negedge clk);
      n_chk++;
      if (wr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear got %b want 0", wr_err);
      end
      check_read(6, 1);
      check_read(7, 1);
   endtask

   task automatic test_tail();
      logic [DW-1:0] d1, d2;
      logic [VLEN-1:0] want;
      int bc;
      d1 = rand_data();
      d2 = rand_data();
      start_write(3, 1, d1, 0, 64, 1'b0);
      wait_done(bc);
      start_write(3, 1, d2, 0, 3, 1'b0);
      wait_done(bc);
      check_read(3, 1);
`ifdef VRF_TAIL_AGNOSTIC_EN
      want = {{(VLEN-24){1'b1}}, d2[23:0]};
`else
      want = {d1[VLEN-1:24], d2[23:0]};
`endif
      n_chk++;
      if (rdata_1[VLEN-1:0] !== want) begin
         n_fail++;
         $display("FAIL tail got %h want %h", rdata_1[63:0], want[63:0]);
      end
   endtask

   task automatic test_random();
      int lm, a, s, v, bc;
      logic mop;
      logic [DW-1:0] d;
      for (int i = 0; i < 8; i++) begin
         lm  = 1 << $urandom_range(0, 3);
         a   = $urandom_range(0, NUM_REGS-1) & ~(lm-1);
         s   = $urandom_range(0, 3);
         v   = (i == 0) ? 0 : $urandom_range(0, VLEN);
         mop = 1'($urandom_range(0, 1));
         d   = rand_data();
         start_write(a, lm, d, s, v, mop);
         wait_done(bc);
         n_chk++;
         if (bc != lm + 1) begin
            n_fail++;
            $display("FAIL rand_busy got %0d want %0d", bc, lm+1);
         end
         check_read(a, lm);
         n_chk++;
         if (v0_mask_data !== mdl[0]) begin
            n_fail++;
            $display("FAIL rand_v0 got %h want %h",
                     v0_mask_data[63:0], mdl[0][63:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      d = rand_data() | {(DW/32){32'h1}};
      start_write(16, 8, d, 3, VLEN, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      sbq.delete();
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
      @(negedge clk);
      reset = 1'b0;
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_busy got %b want 0", busy);
      end
      repeat (12) begin
         @(negedge clk);
         n_chk++;
         if (data_written !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_dw got %b want 0", data_written);
         end
      end
      for (int i = 0; i < NUM_REGS; i++) check_read(i, 1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_group4();
      test_mask();
      test_wr_err();
      test_tail();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d want completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
